regfile_cmd_master: RTL and testbench
=====================================

Name: regfile_cmd_master

Overview:
- Initiator for the 32x32 register file: synchronous write, asynchronous dual-port read, plus a debug read port.
- Accepts one command at a time over a valid/ready handshake.
- For each command it reads operands through the file's two read ports, computes a 32-bit result, and writes it back through the single write port.
- Also provides a whole-file clear sweep. Sits between the test/control logic and the regfile instance in the datapath lab top.

Parameters:
- PROTECT_R0, 1, when 1 every write whose target is address 0 is suppressed (rf_wen held low); when 0, r0 is writable.
- CLR_VALUE, 32'h0000_0000, data written to each register by the CLR sweep.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; high exactly when state is IDLE.
- cmd_op  input  3  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 LUI, 7 CLR.
- cmd_rs  input  5  source register 1.
- cmd_rt  input  5  source register 2.
- cmd_rd  input  5  destination register.
- cmd_imm  input  16  immediate; used by LUI only.
- rf_raddr1  output  5  to regfile raddr1.
- rf_raddr2  output  5  to regfile raddr2.
- rf_rdata1  input  32  from regfile rdata1.
- rf_rdata2  input  32  from regfile rdata2.
- rf_wen  output  1  to regfile wen.
- rf_waddr  output  5  to regfile waddr.
- rf_wdata  output  32  to regfile wdata.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when a command completes.
- result  output  32  last computed result; holds until the next completion.

Behaviour:
- Reset: async, active-high. While asserted and after release:
  - state = IDLE;
  - rf_wen, done, busy = 0;
  - rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, result = 0;
  - sweep counter = 0;
  - cmd_ready = 1.
- Reset during any state aborts the command immediately. rf_wen drops asynchronously, so no partial write is issued after reset assertion.
- Handshake: a command is accepted on the rising edge where cmd_valid && cmd_ready. op/rs/rt/rd/imm are latched at that edge. Inputs are ignored while busy. cmd_valid held high across back-to-back commands is legal.
- States: IDLE, READ, EXEC, WRITE, SWEEP.
- IDLE -> READ on accept with op 0-6. IDLE -> SWEEP on accept with op 7.
- READ (1 cycle):
  - rf_raddr1 = rs, rf_raddr2 = rt.
  - Async read data is captured into operand registers A and B at the end of the cycle.
  - Go to EXEC.
- EXEC (1 cycle): result register <= f(A, B, imm); go to WRITE.
  - ADD/SUB: 32-bit wrap-around, no overflow flag.
  - AND, OR, XOR: bitwise.
  - SLT: signed compare, result is 32'h1 if A<B else 32'h0.
  - LUI: {imm, 16'h0}; operands are ignored.
- WRITE (1 cycle):
  - rf_wen = 1, rf_waddr = rd, rf_wdata = result.
  - If PROTECT_R0 && rd == 0, rf_wen = 0.
  - Next state IDLE. done = 1 in the following cycle; done is registered and coincides with cmd_ready = 1.
- Latency: accept at edge N; write commits at edge N+3; done high during cycle N+3..N+4. A new command may be accepted on the edge that ends the done cycle.
  - Because the write has already committed, a dependent command reads the updated value; no hazard logic is needed.
- SWEEP (32 cycles):
  - Counter runs 0..31; rf_wen = 1, rf_waddr = counter, rf_wdata = CLR_VALUE.
  - Address 0 is suppressed per PROTECT_R0.
  - Counter wraps 31 -> 0 on exit. Next state IDLE with done pulse. result is unchanged by CLR.
- rf_wen is low in every state other than WRITE and SWEEP.
- rf_raddr1 and rf_raddr2 hold their last value outside READ.
- RS == RT is legal.
- RD == RS is legal: the read completes before the write.

Test Plan:
- Reset, then ADD rs=1 (0x0000_0005), rt=2 (0xFFFF_FFFF), rd=3 -> rf_wen pulses at accept+3 with waddr 3, wdata 0x0000_0004; done the next cycle; r3 = 4.
- SUB r4 = r1 - r2 with r1=0, r2=1 -> 0xFFFF_FFFF; SLT r5 with r1=0xFFFF_FFFF, r2=1 -> 0x1 (signed).
- LUI rd=0, imm=0xABCD, PROTECT_R0=1 -> rf_wen stays 0, r0 stays 0, done still pulses, result=0xABCD_0000; same with PROTECT_R0=0 -> r0 = 0xABCD_0000.
- Back-to-back with cmd_valid held: LUI r6=0x1234_0000 then OR r7=r6|r6 -> second command accepted on the done edge, r7 = 0x1234_0000; cmd_ready low for exactly 3 cycles per command.
- Preload all registers to 0xFFFF_FFFF, issue CLR -> 32 consecutive write cycles with addresses 0..31 (address 0 suppressed when protected), busy for 32 cycles, all registers = CLR_VALUE afterwards.
- Assert reset in WRITE cycle and at sweep count 10 -> rf_wen falls without waiting for clk, target register unchanged, registers 10..31 untouched, cmd_ready = 1 after release.

Source files
------------

// File: rtl/regfile_cmd_master.sv
// regfile_cmd_master: command initiator for a 32x32 register file.
// Each command is accepted over a valid/ready handshake.
// An ALU command reads two operands, computes a result and writes it back.
// CLR sweeps CLR_VALUE over every register in turn.
module regfile_cmd_master #(
   parameter bit          PROTECT_R0 = 1'b1,
   parameter logic [31:0] CLR_VALUE  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [4:0]  cmd_rs,
   input  logic [4:0]  cmd_rt,
   input  logic [4:0]  cmd_rd,
   input  logic [15:0] cmd_imm,
   output logic [4:0]  rf_raddr1,
   output logic [4:0]  rf_raddr2,
   input  logic [31:0] rf_rdata1,
   input  logic [31:0] rf_rdata2,
   output logic        rf_wen,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_SWEEP = 3'd4;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SLT = 3'd5;
   localparam logic [2:0] OP_LUI = 3'd6;
   localparam logic [2:0] OP_CLR = 3'd7;

   logic [2:0]  state;
   logic [2:0]  op_q;
   logic [4:0]  rd_q;
   logic [15:0] imm_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [4:0]  cnt;
   logic [31:0] alu_out;

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   // Result function of the latched opcode over the captured operands.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      alu_out = 32'h0;
      case (op_q)
         OP_ADD:  alu_out = a_q + b_q;
         OP_SUB:  alu_out = a_q - b_q;
         OP_AND:  alu_out = a_q & b_q;
         OP_OR:   alu_out = a_q | b_q;
         OP_XOR:  alu_out = a_q ^ b_q;
         OP_SLT:  alu_out = ($signed(a_q) < $signed(b_q)) ? 32'h1 : 32'h0;
         OP_LUI:  alu_out = {imm_q, 16'h0};
         default: alu_out = 32'h0;
      endcase
   end

   // Write port: decoded from state so that reset drops rf_wen without waiting for a clock edge.
   always_comb begin
      rf_wen   = 1'b0;
      rf_waddr = rd_q;
      rf_wdata = result;
      if (state == S_WRITE) begin
         rf_wen = !(PROTECT_R0 && (rd_q == 5'd0));
      end else if (state == S_SWEEP) begin
         rf_waddr = cnt;
         rf_wdata = CLR_VALUE;
         rf_wen   = !(PROTECT_R0 && (cnt == 5'd0));
      end
   end

   // Command sequencer: accept, read, execute, write back or sweep, then pulse done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         op_q      <= 3'd0;
         rd_q      <= 5'd0;
         imm_q     <= 16'h0;
         a_q       <= 32'h0;
         b_q       <= 32'h0;
         cnt       <= 5'd0;
         done      <= 1'b0;
         result    <= 32'h0;
         rf_raddr1 <= 5'd0;
         rf_raddr2 <= 5'd0;
      end else begin
         // NOTE: non-blocking assignments let every register see pre-edge values, independent of statement order.
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q  <= cmd_op;
                  rd_q  <= cmd_rd;
                  imm_q <= cmd_imm;
                  if (cmd_op == OP_CLR) begin
                     state <= S_SWEEP;
                  end else begin
                     rf_raddr1 <= cmd_rs;
                     rf_raddr2 <= cmd_rt;
                     state     <= S_READ;
                  end
               end
            end
            S_READ: begin
               a_q   <= rf_rdata1;
               b_q   <= rf_rdata2;
               state <= S_EXEC;
            end
            S_EXEC: begin
               result <= alu_out;
               state  <= S_WRITE;
            end
            S_WRITE: begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
            S_SWEEP: begin
               // The counter wraps 31 -> 0 on exit, ready for the next sweep.
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Bench for regfile_cmd_master: two instances (r0 protected / unprotected) share
// stimulus, each driving its own behavioural register file.
module tb_regfile_cmd_master;

   localparam logic [31:0] CLR = 32'hC001_D00D;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [2:0]  cmd_op = 3'd0;
   logic [4:0]  cmd_rs = 5'd0, cmd_rt = 5'd0, cmd_rd = 5'd0;
   logic [15:0] cmd_imm = 16'h0;

   logic        ready_p, busy_p, done_p, wen_p;
   logic [4:0]  raddr1_p, raddr2_p, waddr_p;
   logic [31:0] rdata1_p, rdata2_p, wdata_p, result_p;
   logic        ready_u, busy_u, done_u, wen_u;
   logic [4:0]  raddr1_u, raddr2_u, waddr_u;
   logic [31:0] rdata1_u, rdata2_u, wdata_u, result_u;

   // Register files (bench-owned) and the reference model's view of them.
   logic [31:0] mem_p [32];
   logic [31:0] mem_u [32];
   logic [31:0] mdl_p [32];
   logic [31:0] mdl_u [32];
   logic [31:0] exp_res_p = 32'h0, exp_res_u = 32'h0;

   logic        bd_we = 1'b0;
   logic [4:0]  bd_addr = 5'd0;
   logic [31:0] bd_data = 32'h0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   regfile_cmd_master #(.PROTECT_R0(1'b1), .CLR_VALUE(CLR)) u_dut_p (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_p),
      .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
      .rf_raddr1(raddr1_p), .rf_raddr2(raddr2_p), .rf_rdata1(rdata1_p), .rf_rdata2(rdata2_p),
      .rf_wen(wen_p), .rf_waddr(waddr_p), .rf_wdata(wdata_p),
      .busy(busy_p), .done(done_p), .result(result_p)
   );

   regfile_cmd_master #(.PROTECT_R0(1'b0), .CLR_VALUE(CLR)) u_dut_u (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_u),
      .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
      .rf_raddr1(raddr1_u), .rf_raddr2(raddr2_u), .rf_rdata1(rdata1_u), .rf_rdata2(rdata2_u),
      .rf_wen(wen_u), .rf_waddr(waddr_u), .rf_wdata(wdata_u),
      .busy(busy_u), .done(done_u), .result(result_u)
   );

   assign rdata1_p = mem_p[raddr1_p];
   assign rdata2_p = mem_p[raddr2_p];
   assign rdata1_u = mem_u[raddr1_u];
   assign rdata2_u = mem_u[raddr2_u];

   // Synchronous write ports plus a backdoor used only while the DUTs are idle.
   always @(posedge clk) begin
      if (wen_p) mem_p[waddr_p] <= wdata_p;
      if (wen_u) mem_u[waddr_u] <= wdata_u;
      if (bd_we) begin
         mem_p[bd_addr] <= bd_data;
         mem_u[bd_addr] <= bd_data;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [15:0] imm);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd6: return {imm, 16'h0};
         default: return 32'd0;
      endcase
   endfunction

   // Called at a negedge; returns at the next negedge.
   task automatic bd_write(input logic [4:0] addr, input logic [31:0] data);
      bd_we = 1'b1;
      bd_addr = addr;
      bd_data = data;
      mdl_p[addr] = data;
      mdl_u[addr] = data;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic check_all_mem(input string tag);
      for (int a = 0; a < 32; a++) begin
         check($sformatf("%s_mem_p[%0d]", tag, a), mem_p[a], mdl_p[a]);
         check($sformatf("%s_mem_u[%0d]", tag, a), mem_u[a], mdl_u[a]);
      end
   endtask

   // One ALU command with cycle-by-cycle checks; returns at the negedge of the done cycle.
   task automatic run_cmd(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [15:0] imm, input bit keep_valid);
      logic [31:0] ep, eu;
      ep = model_alu(op, mdl_p[rs], mdl_p[rt], imm);
      eu = model_alu(op, mdl_u[rs], mdl_u[rt], imm);
      check("ready_before", ready_p, 1);
      cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_imm = imm;
      cmd_valid = 1'b1;
      @(negedge clk);
      if (!keep_valid) cmd_valid = 1'b0;
      check("read_raddr1", raddr1_p, rs);
      check("read_raddr2", raddr2_p, rt);
      check("read_ready", ready_p, 0);
      check("read_busy", busy_p, 1);
      @(negedge clk);
      check("exec_ready", ready_p, 0);
      check("exec_wen", wen_p, 0);
      @(negedge clk);
      check("write_ready", ready_p, 0);
      check("write_wen_p", wen_p, (rd != 5'd0));
      check("write_wen_u", wen_u, 1);
      check("write_waddr", waddr_p, rd);
      check("write_wdata_p", wdata_p, ep);
      check("write_wdata_u", wdata_u, eu);
      @(negedge clk);
      check("done_p", done_p, 1);
      check("done_u", done_u, 1);
      check("done_ready", ready_p, 1);
      check("done_busy", busy_p, 0);
      check("result_p", result_p, ep);
      check("result_u", result_u, eu);
      if (rd != 5'd0) mdl_p[rd] = ep;
      mdl_u[rd] = eu;
      exp_res_p = ep;
      exp_res_u = eu;
      check("wb_mem_p", mem_p[rd], mdl_p[rd]);
      check("wb_mem_u", mem_u[rd], mdl_u[rd]);
   endtask

   // Full CLR sweep with per-cycle checks; returns at the negedge of the done cycle.
   task automatic run_clr();
      check("clr_ready_before", ready_p, 1);
      cmd_op = 3'd7; cmd_rd = 5'($urandom); cmd_rs = 5'($urandom); cmd_rt = 5'($urandom);
      cmd_valid = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (i == 0) cmd_valid = 1'b0;
         check($sformatf("sweep%0d_busy", i), busy_p, 1);
         check($sformatf("sweep%0d_ready", i), ready_u, 0);
         check($sformatf("sweep%0d_waddr", i), waddr_p, i);
         check($sformatf("sweep%0d_wdata", i), wdata_p, CLR);
         check($sformatf("sweep%0d_wen_p", i), wen_p, (i != 0));
         check($sformatf("sweep%0d_wen_u", i), wen_u, 1);
      end
      @(negedge clk);
      check("clr_done", done_p, 1);
      check("clr_ready", ready_p, 1);
      check("clr_busy", busy_p, 0);
      check("clr_result_p", result_p, exp_res_p);
      check("clr_result_u", result_u, exp_res_u);
      for (int a = 0; a < 32; a++) begin
         if (a != 0) mdl_p[a] = CLR;
         mdl_u[a] = CLR;
      end
      check_all_mem("clr");
   endtask

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic [2:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic [31:0] exp;
   } vec_t;

   vec_t tv [10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = '{32'h0000_0005, 32'hFFFF_FFFF, 3'd0, 5'd1, 5'd2, 5'd3,  16'h0,    32'h0000_0004};
      tv[1] = '{32'h0000_0000, 32'h0000_0001, 3'd1, 5'd1, 5'd2, 5'd4,  16'h0,    32'hFFFF_FFFF};
      tv[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'd5, 5'd1, 5'd2, 5'd5,  16'h0,    32'h0000_0001};
      tv[3] = '{32'h0000_0001, 32'hFFFF_FFFF, 3'd5, 5'd1, 5'd2, 5'd8,  16'h0,    32'h0000_0000};
      tv[4] = '{32'h0000_0007, 32'h0000_0007, 3'd5, 5'd1, 5'd2, 5'd8,  16'h0,    32'h0000_0000};
      tv[5] = '{32'hF0F0_1234, 32'h0FF0_FF00, 3'd2, 5'd1, 5'd2, 5'd9,  16'h0,    32'h00F0_1200};
      tv[6] = '{32'hF0F0_1234, 32'h0FF0_FF00, 3'd3, 5'd1, 5'd2, 5'd9,  16'h0,    32'hFFF0_FF34};
      tv[7] = '{32'hF0F0_1234, 32'h0FF0_FF00, 3'd4, 5'd1, 5'd2, 5'd9,  16'h0,    32'hFF00_ED34};
      tv[8] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 5'd1, 5'd2, 5'd1,  16'h0,    32'h0000_0000};
      tv[9] = '{32'h0000_0000, 32'h0000_0000, 3'd6, 5'd0, 5'd0, 5'd0,  16'hABCD, 32'hABCD_0000};

      // Reset state.
      @(negedge clk);
      for (int a = 0; a < 32; a++) bd_write(5'(a), 32'h0);
      check("rst_ready", ready_p, 1);
      check("rst_busy", busy_p, 0);
      check("rst_done", done_p, 0);
      check("rst_wen_p", wen_p, 0);
      check("rst_wen_u", wen_u, 0);
      check("rst_raddr1", raddr1_p, 0);
      check("rst_raddr2", raddr2_p, 0);
      check("rst_waddr", waddr_p, 0);
      check("rst_wdata", wdata_p, 0);
      check("rst_result", result_p, 0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", ready_u, 1);
      check("post_rst_wen", wen_p, 0);

      // Directed vectors.
      for (int i = 0; i < 10; i++) begin
         bd_write(tv[i].rs, tv[i].va);
         bd_write(tv[i].rt, tv[i].vb);
         run_cmd(tv[i].op, tv[i].rs, tv[i].rt, tv[i].rd, tv[i].imm, 1'b0);
         check($sformatf("tbl%0d_result", i), result_p, tv[i].exp);
      end
      check("lui_r0_protected", mem_p[0], 32'h0);
      check("lui_r0_unprotected", mem_u[0], 32'hABCD_0000);

      // Back-to-back with cmd_valid held high.
      run_cmd(3'd6, 5'd0, 5'd0, 5'd6, 16'h1234, 1'b1);
      run_cmd(3'd3, 5'd6, 5'd6, 5'd7, 16'h0, 1'b0);
      check("b2b_r7", mem_p[7], 32'h1234_0000);

      // Full clear sweep from all-ones.
      for (int a = 0; a < 32; a++) bd_write(5'(a), 32'hFFFF_FFFF);
      run_clr();

      // Reset during WRITE.
      bd_write(5'd10, 32'h11);
      bd_write(5'd11, 32'h22);
      bd_write(5'd12, 32'hDEAD_BEEF);
      cmd_op = 3'd0; cmd_rs = 5'd10; cmd_rt = 5'd11; cmd_rd = 5'd12; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rw_wen_before", wen_p, 1);
      #1 reset = 1'b1;
      #1;
      check("rw_wen_p_async", wen_p, 0);
      check("rw_wen_u_async", wen_u, 0);
      check("rw_ready_async", ready_p, 1);
      @(negedge clk);
      reset = 1'b0;
      exp_res_p = 32'h0;
      exp_res_u = 32'h0;
      check("rw_r12_p", mem_p[12], 32'hDEAD_BEEF);
      check("rw_r12_u", mem_u[12], 32'hDEAD_BEEF);
      check("rw_result", result_p, 0);
      check("rw_done", done_p, 0);

      // Reset at sweep count 10.
      for (int a = 0; a < 32; a++) bd_write(5'(a), 32'h5A00_0000 | 32'(a));
      cmd_op = 3'd7; cmd_valid = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         @(negedge clk);
         if (i == 0) cmd_valid = 1'b0;
      end
      check("rs_waddr_before", waddr_p, 10);
      check("rs_wen_before", wen_p, 1);
      #1 reset = 1'b1;
      #1;
      check("rs_wen_p_async", wen_p, 0);
      check("rs_wen_u_async", wen_u, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int a = 0; a < 10; a++) begin
         if (a != 0) mdl_p[a] = CLR;
         mdl_u[a] = CLR;
      end
      check_all_mem("rs");
      check("rs_ready", ready_p, 1);
      check("rs_busy", busy_p, 0);
      @(negedge clk);

      // Randomized commands against the reference model.
      for (int a = 0; a < 32; a++) bd_write(5'(a), $urandom);
      for (int n = 0; n < 60; n++) begin
         if (n % 20 == 19) begin
            run_clr();
         end else begin
            run_cmd(3'($urandom_range(0, 6)), 5'($urandom), 5'($urandom), 5'($urandom),
                    16'($urandom), 1'($urandom_range(0, 1)));
         end
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      check_all_mem("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
